// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU run-control sequencer: state encoding, error codes
// and the default handshake timeout.
package cpu_ctrl_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_CALIB = 3'd1;
  localparam logic [2:0] ST_START      = 3'd2;
  localparam logic [2:0] ST_WAIT_RUN   = 3'd3;
  localparam logic [2:0] ST_RUN        = 3'd4;
  localparam logic [2:0] ST_QUIT       = 3'd5;
  localparam logic [2:0] ST_DRAIN      = 3'd6;
  localparam logic [2:0] ST_DONE       = 3'd7;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RUN_TMO = 2'd1;
  localparam logic [1:0] ERR_DRN_TMO = 2'd2;
  localparam logic [1:0] ERR_UNEXP   = 2'd3;

  localparam logic [7:0] TMO_MAX_DEF = 8'd200;

  // States in which the handshake timeout runs.
  function automatic logic is_tmo_state(input logic [2:0] st);
    return (st == ST_WAIT_RUN) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/ctrl_tmo_cntr.sv
// Saturating handshake timeout counter with synchronous clear; hit_o flags the cycle
// whose count completes limit_i enabled cycles.
module ctrl_tmo_cntr #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o,
  output logic         hit_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  // Not gated by clr_i: the clear is derived from the next state, which uses hit_o.
  assign hit_o = en_i && (({1'b0, cnt_q} + (W + 1)'(1)) >= {1'b0, limit_i});

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: turns monitor go/stop requests into timed start/quit pulses
// for the CPU status block, with optional cycle budget and bounded handshakes.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned      CYC_W   = 32,
  parameter int unsigned      TMO_W   = 8,
  parameter logic [TMO_W-1:0] TMO_MAX = TMO_W'(TMO_MAX_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_calib_complete,
  input  logic             cmd_start,
  input  logic [31:2]      cmd_adr,
  input  logic [CYC_W-1:0] cmd_cycles,
  input  logic             cmd_stop,
  input  logic             cpu_run_state,
  input  logic             cpu_stopping,
  output logic             cpu_start,
  output logic [31:2]      start_adr,
  output logic             quit_cmd,
  output logic             ctrl_busy,
  output logic             done,
  output logic [1:0]       err,
  output logic             cmd_rej,
  output logic [CYC_W-1:0] run_cycles
);

  logic [2:0]       state_q, state_d;
  logic [31:2]      adr_q, adr_d;
  logic [CYC_W-1:0] budget_q, budget_d;
  logic [1:0]       err_q, err_d;
  logic [CYC_W-1:0] run_cycles_q, run_cycles_d;
  logic             cpu_start_q, quit_cmd_q, done_q, busy_q, cmd_rej_q;

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             tmo_clr;
  logic             tmo_en;
  logic [CYC_W-1:0] run_cycles_inc;
  logic             budget_hit;
  logic             drain_ok;

  assign tmo_en  = is_tmo_state(state_q);
  assign tmo_clr = (state_d != state_q);

  ctrl_tmo_cntr #(
    .W (TMO_W)
  ) u_tmo (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (tmo_clr),
    .en_i    (tmo_en),
    .limit_i (TMO_MAX),
    .cnt_o   (tmo_cnt),
    .hit_o   (tmo_hit)
  );

  assign run_cycles_inc = (&run_cycles_q) ? run_cycles_q : run_cycles_q + CYC_W'(1);
  // Compared one bit wider so a saturated counter cannot wrap into a false budget hit.
  assign budget_hit = (budget_q != '0) &&
                      (({1'b0, run_cycles_q} + (CYC_W + 1)'(1)) == {1'b0, budget_q});
  // The status block raises cpu_stopping only after quit_cmd, so never leave DRAIN
  // in its first cycle.
  assign drain_ok = !cpu_stopping && !cpu_run_state && (tmo_cnt != '0);

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    budget_d     = budget_q;
    err_d        = err_q;
    run_cycles_d = run_cycles_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          adr_d        = cmd_adr;
          budget_d     = cmd_cycles;
          err_d        = ERR_NONE;
          run_cycles_d = '0;
          state_d      = init_calib_complete ? ST_START : ST_WAIT_CALIB;
        end
      end
      ST_WAIT_CALIB: begin
        if (init_calib_complete) begin
          state_d = ST_START;
        end else if (cmd_stop) begin
          state_d = ST_DONE;
        end
      end
      ST_START: state_d = ST_WAIT_RUN;
      ST_WAIT_RUN: begin
        if (cpu_run_state) begin
          state_d = ST_RUN;
        end else if (tmo_hit) begin
          err_d   = ERR_RUN_TMO;
          state_d = ST_QUIT;
        end else if (cmd_stop) begin
          state_d = ST_QUIT;
        end
      end
      ST_RUN: begin
        run_cycles_d = run_cycles_inc;
        if (cmd_stop || budget_hit) begin
          state_d = ST_QUIT;
        end else if (!cpu_run_state) begin
          err_d   = ERR_UNEXP;
          state_d = ST_DONE;
        end
      end
      ST_QUIT: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (drain_ok) begin
          state_d = ST_DONE;
        end else if (tmo_hit) begin
          err_d   = ERR_DRN_TMO;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      adr_q        <= '0;
      budget_q     <= '0;
      err_q        <= ERR_NONE;
      run_cycles_q <= '0;
      cpu_start_q  <= 1'b0;
      quit_cmd_q   <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      cmd_rej_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      budget_q     <= budget_d;
      err_q        <= err_d;
      run_cycles_q <= run_cycles_d;
      cpu_start_q  <= (state_d == ST_START);
      quit_cmd_q   <= (state_d == ST_QUIT);
      done_q       <= (state_d == ST_DONE);
      busy_q       <= (state_d != ST_IDLE);
      cmd_rej_q    <= cmd_start && (state_q != ST_IDLE);
    end
  end

  assign cpu_start  = cpu_start_q;
  assign start_adr  = adr_q;
  assign quit_cmd   = quit_cmd_q;
  assign ctrl_busy  = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cmd_rej    = cmd_rej_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a sequential transaction model predicts every output each
// cycle, and directed scenarios pin key timings with literal expectations.
module tb_cpu_run_ctrl;

  localparam int TMO = 200;
  localparam int SIG_START = 0;
  localparam int SIG_QUIT  = 1;
  localparam int SIG_DONE  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_calib_complete = 1'b1;
  logic        cmd_start = 1'b0;
  logic [31:2] cmd_adr = '0;
  logic [31:0] cmd_cycles = '0;
  logic        cmd_stop = 1'b0;
  logic        run_st, stopping;
  logic        cpu_start, quit_cmd, ctrl_busy, done, cmd_rej;
  logic [31:2] start_adr;
  logic [1:0]  err;
  logic [31:0] run_cycles;

  cpu_run_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .init_calib_complete (init_calib_complete),
    .cmd_start           (cmd_start),
    .cmd_adr             (cmd_adr),
    .cmd_cycles          (cmd_cycles),
    .cmd_stop            (cmd_stop),
    .cpu_run_state       (run_st),
    .cpu_stopping        (stopping),
    .cpu_start           (cpu_start),
    .start_adr           (start_adr),
    .quit_cmd            (quit_cmd),
    .ctrl_busy           (ctrl_busy),
    .done                (done),
    .err                 (err),
    .cmd_rej             (cmd_rej),
    .run_cycles          (run_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Status block stand-in: running one edge after cpu_start, stopping one edge after
  // quit_cmd, drain finishes a few cycles later unless held stuck.
  logic       sm_respond = 1'b1;
  logic       sm_stuck = 1'b0;
  logic       sm_drop = 1'b0;
  logic [3:0] drain_cnt;

  always @(posedge clk) begin
    if (rst) begin
      run_st    <= 1'b0;
      stopping  <= 1'b0;
      drain_cnt <= '0;
    end else begin
      if (cpu_start && sm_respond) run_st <= 1'b1;
      if (sm_drop) run_st <= 1'b0;
      if (quit_cmd) begin
        stopping  <= 1'b1;
        drain_cnt <= 4'd3;
      end else if (stopping && !sm_stuck) begin
        if (drain_cnt == 0) begin
          stopping <= 1'b0;
          run_st   <= 1'b0;
        end else begin
          drain_cnt <= drain_cnt - 4'd1;
        end
      end
    end
  end

  int n_start_pulses = 0;
  int n_quit_pulses = 0;
  always @(posedge clk) begin
    if (cpu_start) n_start_pulses++;
    if (quit_cmd) n_quit_pulses++;
  end

  // ---------------- transaction model ----------------
  logic        s_rst, s_start, s_calib, s_stop, s_run, s_stopping;
  logic [29:0] s_adr;
  logic [31:0] s_cyc;
  logic        e_start = 1'b0, e_quit = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_rej = 1'b0;
  logic [29:0] e_adr = '0;
  logic [1:0]  e_err = '0;
  logic [31:0] e_rc = '0;

  // One clock edge: sample what the DUT sees, retire last cycle's pulses.
  task automatic tick(output bit ab);
    @(posedge clk);
    s_rst = rst; s_start = cmd_start; s_calib = init_calib_complete; s_stop = cmd_stop;
    s_run = run_st; s_stopping = stopping; s_adr = cmd_adr; s_cyc = cmd_cycles;
    e_rej = s_start && e_busy && !s_rst;
    e_start = 1'b0; e_quit = 1'b0; e_done = 1'b0;
    ab = s_rst;
    if (s_rst) begin
      e_busy = 1'b0; e_adr = '0; e_err = 2'd0; e_rc = '0;
    end
  endtask

  task automatic model_done();
    bit ab;
    e_done = 1'b1;
    tick(ab);
    if (!ab) e_busy = 1'b0;
  endtask

  task automatic model_quit_drain();
    bit ab;
    int n;
    e_quit = 1'b1;
    tick(ab);
    if (ab) return;
    n = 0;
    forever begin
      tick(ab);
      if (ab) return;
      n++;
      if (n > 1 && !s_stopping && !s_run) break;
      if (n == TMO) begin
        e_err = 2'd2;
        break;
      end
    end
    model_done();
  endtask

  task automatic model_txn();
    bit ab;
    int n;
    logic [31:0] budget;
    logic [31:0] cnt;
    do tick(ab); while (ab || !s_start);
    e_adr = s_adr; budget = s_cyc; e_err = 2'd0; e_rc = '0; e_busy = 1'b1;
    if (!s_calib) begin
      forever begin
        tick(ab);
        if (ab) return;
        if (s_calib) break;
        if (s_stop) begin
          model_done();
          return;
        end
      end
    end
    e_start = 1'b1;
    tick(ab);
    if (ab) return;
    n = 0;
    forever begin
      tick(ab);
      if (ab) return;
      n++;
      if (s_run) break;
      if (n == TMO || s_stop) begin
        if (n == TMO) e_err = 2'd1;
        model_quit_drain();
        return;
      end
    end
    cnt = '0;
    forever begin
      tick(ab);
      if (ab) return;
      if (cnt != '1) cnt++;
      e_rc = cnt;
      if (s_stop || (budget != 0 && cnt == budget)) begin
        model_quit_drain();
        return;
      end
      if (!s_run) begin
        e_err = 2'd3;
        model_done();
        return;
      end
    end
  endtask

  initial forever model_txn();

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cpu_start", 64'(cpu_start), 64'(e_start));
      if (e_start) chk("start_adr", 64'(start_adr), 64'(e_adr));
      chk("quit_cmd", 64'(quit_cmd), 64'(e_quit));
      chk("ctrl_busy", 64'(ctrl_busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("err", 64'(err), 64'(e_err));
      chk("cmd_rej", 64'(cmd_rej), 64'(e_rej));
      chk("run_cycles", 64'(run_cycles), 64'(e_rc));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic pick(input int sel);
    case (sel)
      SIG_START: return cpu_start;
      SIG_QUIT:  return quit_cmd;
      SIG_DONE:  return done;
      default:   return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int limit, input string what, output int n);
    n = 0;
    while (!pick(sel) && n <= limit) begin
      @(negedge clk);
      n++;
    end
    if (!pick(sel)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: pulse not seen within %0d cycles", what, limit);
    end
  endtask

  task automatic wait_rc(input logic [31:0] v, input int limit, input string what);
    int n;
    n = 0;
    while (run_cycles != v && n <= limit) begin
      @(negedge clk);
      n++;
    end
    if (run_cycles != v) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: run_cycles %0d never reached %0d", what, run_cycles, v);
    end
  endtask

  // Returns at the negedge after the accepting edge.
  task automatic go(input logic [29:0] adr, input logic [31:0] cyc);
    cmd_start = 1'b1; cmd_adr = adr; cmd_cycles = cyc;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int q0;
    int s0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset busy", 64'(ctrl_busy), 64'(0));
    chk("reset err", 64'(err), 64'(0));
    chk("reset run_cycles", 64'(run_cycles), 64'(0));
    chk("reset start_adr", 64'(start_adr), 64'(0));

    // Stop in IDLE is ignored.
    cmd_stop = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0;
    chk("idle stop busy", 64'(ctrl_busy), 64'(0));
    chk("idle stop done", 64'(done), 64'(0));

    // Basic budget run: START, one WAIT_RUN cycle, 10 RUN cycles, then QUIT.
    s0 = n_start_pulses;
    go(30'h40, 32'd10);
    chk("t1 cpu_start", 64'(cpu_start), 64'(1));
    chk("t1 start_adr", 64'(start_adr), 64'(30'h40));
    wait_for(SIG_QUIT, 50, "t1 quit", n);
    chk("t1 start-to-quit", 64'(n), 64'(12));
    chk("t1 run_cycles", 64'(run_cycles), 64'(10));
    wait_for(SIG_DONE, 50, "t1 done", n);
    chk("t1 err", 64'(err), 64'(0));
    chk("t1 start pulses", 64'(n_start_pulses - s0), 64'(1));
    @(negedge clk);
    chk("t1 idle after done", 64'(ctrl_busy), 64'(0));

    // Stop while waiting for calibration.
    init_calib_complete = 1'b0;
    go(30'h80, 32'd5);
    chk("t2 busy", 64'(ctrl_busy), 64'(1));
    repeat (3) @(negedge clk);
    cmd_stop = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0;
    chk("t2 done", 64'(done), 64'(1));
    chk("t2 err", 64'(err), 64'(0));
    @(negedge clk);

    // Calibration wait: calib seen at the next edge, START visible right after.
    go(30'h100, 32'd3);
    repeat (50) @(negedge clk);
    chk("t3 no start before calib", 64'(cpu_start), 64'(0));
    init_calib_complete = 1'b1;
    @(negedge clk);
    chk("t3 start after calib", 64'(cpu_start), 64'(1));
    chk("t3 start_adr", 64'(start_adr), 64'(30'h100));
    wait_for(SIG_DONE, 50, "t3 done", n);
    chk("t3 run_cycles", 64'(run_cycles), 64'(3));
    @(negedge clk);

    // Free run, manual stop during RUN cycle 1000.
    go(30'h200, 32'd0);
    wait_rc(32'd999, 1100, "t4 run");
    cmd_stop = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0;
    chk("t4 quit", 64'(quit_cmd), 64'(1));
    chk("t4 run_cycles", 64'(run_cycles), 64'(1000));
    wait_for(SIG_DONE, 50, "t4 done", n);
    chk("t4 err", 64'(err), 64'(0));
    @(negedge clk);

    // Budget of one gives a single RUN cycle.
    go(30'h3, 32'd1);
    wait_for(SIG_QUIT, 50, "t5 quit", n);
    chk("t5 start-to-quit", 64'(n), 64'(3));
    chk("t5 run_cycles", 64'(run_cycles), 64'(1));
    wait_for(SIG_DONE, 50, "t5 done", n);
    @(negedge clk);

    // Run timeout: WAIT_RUN holds for TMO cycles, then QUIT.
    sm_respond = 1'b0;
    go(30'h10, 32'd10);
    wait_for(SIG_QUIT, 300, "t6 quit", n);
    chk("t6 start-to-quit", 64'(n), 64'(TMO + 1));
    chk("t6 err at quit", 64'(err), 64'(1));
    wait_for(SIG_DONE, 50, "t6 done", n);
    chk("t6 err at done", 64'(err), 64'(1));
    sm_respond = 1'b1;
    @(negedge clk);

    // Drain timeout with cpu_stopping stuck high.
    sm_stuck = 1'b1;
    go(30'h20, 32'd5);
    wait_for(SIG_QUIT, 50, "t7 quit", n);
    wait_for(SIG_DONE, 300, "t7 done", n);
    chk("t7 quit-to-done", 64'(n), 64'(TMO + 1));
    chk("t7 err", 64'(err), 64'(2));
    sm_stuck = 1'b0;
    repeat (6) @(negedge clk);

    // Unexpected stop: run_state drops during RUN, no quit issued.
    q0 = n_quit_pulses;
    go(30'h30, 32'd0);
    wait_rc(32'd5, 50, "t8 run");
    sm_drop = 1'b1;
    @(negedge clk);
    sm_drop = 1'b0;
    wait_for(SIG_DONE, 20, "t8 done", n);
    chk("t8 err", 64'(err), 64'(3));
    chk("t8 run_cycles", 64'(run_cycles), 64'(7));
    @(negedge clk);
    chk("t8 no quit", 64'(n_quit_pulses - q0), 64'(0));

    // Rejected start while busy.
    go(30'h55, 32'd20);
    wait_rc(32'd4, 50, "t9 run");
    cmd_start = 1'b1; cmd_adr = 30'h77; cmd_cycles = 32'd3;
    @(negedge clk);
    cmd_start = 1'b0;
    chk("t9 cmd_rej", 64'(cmd_rej), 64'(1));
    chk("t9 still busy", 64'(ctrl_busy), 64'(1));
    wait_for(SIG_QUIT, 50, "t9 quit", n);
    chk("t9 run_cycles", 64'(run_cycles), 64'(20));
    wait_for(SIG_DONE, 50, "t9 done", n);
    @(negedge clk);

    // Reset in RUN.
    q0 = n_quit_pulses;
    go(30'h66, 32'd0);
    wait_rc(32'd3, 50, "t10 run");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t10 busy", 64'(ctrl_busy), 64'(0));
    chk("t10 start", 64'(cpu_start), 64'(0));
    chk("t10 start_adr", 64'(start_adr), 64'(0));
    chk("t10 quit", 64'(quit_cmd), 64'(0));
    chk("t10 done", 64'(done), 64'(0));
    chk("t10 err", 64'(err), 64'(0));
    chk("t10 rej", 64'(cmd_rej), 64'(0));
    chk("t10 run_cycles", 64'(run_cycles), 64'(0));
    repeat (5) @(negedge clk);
    chk("t10 no quit", 64'(n_quit_pulses - q0), 64'(0));

    // Recovery after reset.
    go(30'h99, 32'd2);
    wait_for(SIG_DONE, 50, "t11 done", n);
    chk("t11 run_cycles", 64'(run_cycles), 64'(2));
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
